// File: rtl/processor_pkg.sv
// Shared widths and the responder state encoding used across the memory slice.
package processor_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACCESS
  } state_e;

endpackage

// File: rtl/ram_array.sv
// Single-port word storage: synchronous write, registered read, never cleared.
module ram_array #(
  parameter int DEPTH = 256,
  parameter int AW    = 8,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_q [DEPTH];

  // Write when enabled and always register the addressed word (old data on a write).
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
    rdata <= mem_q[addr];
  end

endmodule

// File: rtl/mem_responder.sv
// Request/acknowledge memory responder with programmable wait states in front of each access.
module mem_responder
  import processor_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              rw,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] wdata,
  output logic              ready,
  output logic              ack,
  output logic [DATA_W-1:0] rdata,
  output logic              err
);

  localparam int          RAM_AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] DEPTH_U  = 32'(DEPTH);
  localparam logic [3:0]  CNT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              rw_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              ack_q, ack_d;
  logic              err_q, err_d;
  logic              rdSel_q, rdSel_d;
  logic [DATA_W-1:0] hold_q;
  logic              capture;
  logic              we;
  logic              inRange;
  logic [DATA_W-1:0] ramRdata;

  assign inRange = ({16'b0, addr_q} < DEPTH_U);

  // Sequence IDLE -> WAIT -> ACCESS and decide what the access edge does.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    rdSel_d = 1'b0;
    we      = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          capture = 1'b1;
          if (WAIT_STATES > 0) begin
            state_d = WAIT;
            cnt_d   = CNT_LOAD;
          end else begin
            state_d = ACCESS;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ACCESS;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ACCESS: begin
        state_d = IDLE;
        ack_d   = 1'b1;
        err_d   = ~inRange;
        rdSel_d = inRange & ~rw_q;
        we      = inRange & rw_q & ~reset;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counter and response flags; the held read value follows whatever was shown on ack.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdSel_q <= 1'b0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdSel_q <= rdSel_d;
      if (ack_q) begin
        hold_q <= rdata;
      end
    end
  end

  // Latch the request fields only at acceptance so later input changes are ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      rw_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (capture) begin
      rw_q    <= rw;
      addr_q  <= address;
      wdata_q <= wdata;
    end
  end

  ram_array #(
    .DEPTH(DEPTH),
    .AW   (RAM_AW),
    .DW   (DATA_W)
  ) u_ram (
    .clk  (clk),
    .we   (we),
    .addr (addr_q[RAM_AW-1:0]),
    .wdata(wdata_q),
    .rdata(ramRdata)
  );

  assign ready = (state_q == IDLE);
  assign ack   = ack_q;
  assign err   = err_q;
  assign rdata = rdSel_q ? ramRdata : ((ack_q & err_q) ? '0 : hold_q);

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 256, number of 32-bit words stored.
REQ-002 SHALL have parameter WAIT_STATES, default 2, extra cycles inserted before each access (legal 0..15).
REQ-003 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port req  input  1  initiator request strobe.
REQ-006 SHALL have port rw  input  1  request type: 1 = write, 0 = read.
REQ-007 SHALL have port address  input  16  word address.
REQ-008 SHALL have port wdata  input  32  write data.
REQ-009 SHALL have port ready  output  1  responder can accept a request this cycle.
REQ-010 SHALL have port ack  output  1  one-cycle completion pulse.
REQ-011 SHALL have port rdata  output  32  read data, valid when ack=1 for a read.
REQ-012 SHALL have port err  output  1  out-of-range flag, valid only when ack=1.

Function
REQ-013 SHALL implement FSM states IDLE, WAIT, ACCESS; ready=1 only in IDLE.
REQ-014 In IDLE, req=1 at an edge SHALL capture rw, address and wdata into internal registers; next state is WAIT if WAIT_STATES>0, else ACCESS.
REQ-015 On entry to WAIT the counter SHALL load WAIT_STATES-1 and decrement each cycle; when it is 0 the next state is ACCESS.
REQ-016 In ACCESS, the next edge SHALL perform the access, register ack=1 (plus err and rdata), and return to IDLE.
REQ-017 Latency: for req sampled at edge k, ack SHALL be high exactly in the cycle after edge k+WAIT_STATES+1.
REQ-018 ack SHALL be high for exactly one cycle per accepted request.
REQ-019 ready SHALL be 1 during the ack cycle, so the next request can be accepted back-to-back (one transaction per WAIT_STATES+2 cycles).
REQ-020 req while ready=0 SHALL be ignored, with no capture and no side effects.
REQ-021 Inputs SHALL be used only as captured at acceptance; changes during WAIT/ACCESS SHALL have no effect.
REQ-022 A read with captured address < DEPTH SHALL load rdata with mem[address] and set err=0.
REQ-023 A write with captured address < DEPTH SHALL write wdata to mem[address]; rdata SHALL hold its previous value; err=0.
REQ-024 address >= DEPTH SHALL cause no write, rdata=0 and err=1 on the ack cycle.
REQ-025 err SHALL be 0 whenever ack=0.
REQ-026 rdata SHALL hold its last value until the next completed read or reset.
REQ-027 A read after a write to the same address SHALL return the new data.

Reset
REQ-028 reset=1 at an edge SHALL force state IDLE, counter 0, ack=0, err=0 and rdata=0; ready SHALL be 1 after reset.
REQ-029 reset SHALL take priority over every other event; reset at the ACCESS edge SHALL abort the transaction, with no write and no ack.
REQ-030 Storage contents SHALL NOT be cleared by reset.

Structure
REQ-031 The state enum, DATA_W=32 and ADDR_W=16 SHALL be defined in the shared package processor_pkg.
REQ-032 The storage array SHALL be a sub-module ram_array (single port, synchronous write, registered read, ports clk/we/addr/wdata/rdata); the FSM and counter SHALL stay in mem_responder.

Verification
REQ-033 Reset, then write 0xDEADBEEF to address 0x0010 with WAIT_STATES=2 -> ack in the cycle after edge k+3, err=0.
REQ-034 Read 0x0010 -> rdata=0xDEADBEEF with ack, err=0; rdata holds after ack drops.
REQ-035 Read 0x0100 with DEPTH=256 -> ack with err=1 and rdata=0; a following read of 0x00FF returns its stored value with err=0.
REQ-036 Pulse req continuously during WAIT, changing address -> only the first request completes, exactly one ack.
REQ-037 Assert reset at the ACCESS edge of a write of 0x12345678 to 0x0020 -> no ack; a later read of 0x0020 returns the old value.
REQ-038 WAIT_STATES=0, back-to-back writes to 0x0001 and 0x0002, each issued on the previous ack cycle -> acks every 2 cycles, both values read back correctly.
